decode_operand_stage_rv32i: RTL and testbench

- Decode/operand-fetch stage of the RV32I pipeline, between instruction fetch and the execute stage.
- Decodes the instruction and drives read addresses to the register file.
- Resolves operands from register file data or from forwarded MEM/WB results.
- Generates immediates, detects load-use hazards and holds the ID/EX pipeline register with a valid/ready handshake on both sides.

---
 rtl/decode_operand_stage_rv32i.sv | 201 ++++++++++++++++++++
 tb/tb_decode_operand_stage_rv32i.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_operand_stage_rv32i.sv
// RV32I decode/operand-fetch stage: decodes the fetched word, resolves operands
// through the MEM/WB bypass, builds immediates and owns the ID/EX register.
module decode_operand_stage_rv32i #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         if_valid,
    output logic         if_ready,
    input  logic [31:0]  if_instr,
    input  logic [W-1:0] if_pc,
    output logic [4:0]   rf_rs1,
    output logic [4:0]   rf_rs2,
    input  logic [W-1:0] rf_rd1,
    input  logic [W-1:0] rf_rd2,
    input  logic         mem_fwd_we,
    input  logic [4:0]   mem_fwd_rd,
    input  logic [W-1:0] mem_fwd_data,
    input  logic         wb_fwd_we,
    input  logic [4:0]   wb_fwd_rd,
    input  logic [W-1:0] wb_fwd_data,
    input  logic         flush,
    output logic         id_valid,
    input  logic         id_ready,
    output logic [W-1:0] id_pc,
    output logic [W-1:0] id_rs1_val,
    output logic [W-1:0] id_rs2_val,
    output logic [W-1:0] id_imm,
    output logic [4:0]   id_rd,
    output logic [6:0]   id_opcode,
    output logic [2:0]   id_funct3,
    output logic         id_funct7b5,
    output logic         id_we,
    output logic         id_is_load,
    output logic         id_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // MEM beats WB because it carries the younger write to the same register.
    function automatic logic [W-1:0] resolve_operand(
        input logic [4:0]   addr,
        input logic [W-1:0] rf_data,
        input logic         mem_we,
        input logic [4:0]   mem_rd,
        input logic [W-1:0] mem_data,
        input logic         wb_we,
        input logic [4:0]   wb_rd,
        input logic [W-1:0] wb_data
    );
        logic [W-1:0] val;
        if (addr == 5'd0)
            val = '0;
        else if (mem_we && (mem_rd == addr))
            val = mem_data;
        else if (wb_we && (wb_rd == addr))
            val = wb_data;
        else
            val = rf_data;
        return val;
    endfunction

    function automatic logic [W-1:0] gen_imm(input logic [31:0] instr);
        logic [31:0] imm;
        case (instr[6:0])
            OP_JALR, OP_LOAD, OP_IMM: imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm = {instr[31:12], 12'b0};
            OP_JAL:    imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default:   imm = '0;
        endcase
        return W'($signed(imm));
    endfunction

    logic [6:0] opcode;
    logic [4:0] rd;
    logic       rs1_used, rs2_used, writes_rd, legal;
    logic       advance, hazard, load_en;

    logic         id_valid_q, id_valid_d;
    logic [W-1:0] id_pc_q, id_pc_d;
    logic [W-1:0] id_rs1_val_q, id_rs1_val_d;
    logic [W-1:0] id_rs2_val_q, id_rs2_val_d;
    logic [W-1:0] id_imm_q, id_imm_d;
    logic [4:0]   id_rd_q, id_rd_d;
    logic [6:0]   id_opcode_q, id_opcode_d;
    logic [2:0]   id_funct3_q, id_funct3_d;
    logic         id_funct7b5_q, id_funct7b5_d;
    logic         id_we_q, id_we_d;
    logic         id_is_load_q, id_is_load_d;
    logic         id_illegal_q, id_illegal_d;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign rf_rs1 = if_instr[19:15];
    assign rf_rs2 = if_instr[24:20];

    always_comb begin
        rs1_used  = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
        rs2_used  = opcode inside {OP_REG, OP_STORE, OP_BRANCH};
        writes_rd = opcode inside {OP_REG, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        legal     = writes_rd || (opcode inside {OP_STORE, OP_BRANCH});
    end

    // A load in ID/EX has no data yet; stall one cycle so it reaches the MEM bypass.
    assign advance = !id_valid_q || id_ready;
    assign hazard  = id_valid_q && id_is_load_q && (id_rd_q != 5'd0) &&
                     ((rs1_used && (id_rd_q == rf_rs1)) || (rs2_used && (id_rd_q == rf_rs2)));
    assign if_ready = advance && !hazard && !flush;
    assign load_en  = if_ready && if_valid;

    always_comb begin
        id_valid_d    = id_valid_q;
        id_pc_d       = id_pc_q;
        id_rs1_val_d  = id_rs1_val_q;
        id_rs2_val_d  = id_rs2_val_q;
        id_imm_d      = id_imm_q;
        id_rd_d       = id_rd_q;
        id_opcode_d   = id_opcode_q;
        id_funct3_d   = id_funct3_q;
        id_funct7b5_d = id_funct7b5_q;
        id_we_d       = id_we_q;
        id_is_load_d  = id_is_load_q;
        id_illegal_d  = id_illegal_q;

        if (flush)
            id_valid_d = 1'b0;
        else if (advance)
            id_valid_d = if_valid && !hazard;

        if (load_en) begin
            id_pc_d       = if_pc;
            id_rs1_val_d  = resolve_operand(rf_rs1, rf_rd1, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                                            wb_fwd_we, wb_fwd_rd, wb_fwd_data);
            id_rs2_val_d  = resolve_operand(rf_rs2, rf_rd2, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                                            wb_fwd_we, wb_fwd_rd, wb_fwd_data);
            id_imm_d      = gen_imm(if_instr);
            id_rd_d       = rd;
            id_opcode_d   = opcode;
            id_funct3_d   = if_instr[14:12];
            id_funct7b5_d = if_instr[30];
            id_we_d       = writes_rd && (rd != 5'd0);
            id_is_load_d  = (opcode == OP_LOAD);
            id_illegal_d  = !legal;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q    <= 1'b0;
            id_pc_q       <= '0;
            id_rs1_val_q  <= '0;
            id_rs2_val_q  <= '0;
            id_imm_q      <= '0;
            id_rd_q       <= '0;
            id_opcode_q   <= '0;
            id_funct3_q   <= '0;
            id_funct7b5_q <= 1'b0;
            id_we_q       <= 1'b0;
            id_is_load_q  <= 1'b0;
            id_illegal_q  <= 1'b0;
        end else begin
            id_valid_q    <= id_valid_d;
            id_pc_q       <= id_pc_d;
            id_rs1_val_q  <= id_rs1_val_d;
            id_rs2_val_q  <= id_rs2_val_d;
            id_imm_q      <= id_imm_d;
            id_rd_q       <= id_rd_d;
            id_opcode_q   <= id_opcode_d;
            id_funct3_q   <= id_funct3_d;
            id_funct7b5_q <= id_funct7b5_d;
            id_we_q       <= id_we_d;
            id_is_load_q  <= id_is_load_d;
            id_illegal_q  <= id_illegal_d;
        end
    end

    assign id_valid    = id_valid_q;
    assign id_pc       = id_pc_q;
    assign id_rs1_val  = id_rs1_val_q;
    assign id_rs2_val  = id_rs2_val_q;
    assign id_imm      = id_imm_q;
    assign id_rd       = id_rd_q;
    assign id_opcode   = id_opcode_q;
    assign id_funct3   = id_funct3_q;
    assign id_funct7b5 = id_funct7b5_q;
    assign id_we       = id_we_q;
    assign id_is_load  = id_is_load_q;
    assign id_illegal  = id_illegal_q;

endmodule

// File: tb/tb_decode_operand_stage_rv32i.sv
// Directed bench for decode_operand_stage_rv32i: expected ID/EX contents are
// queued at the fetch handshake and compared when execute consumes them.
module tb_decode_operand_stage_rv32i;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_we;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rd;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic        id_funct7b5, id_we, id_is_load, id_illegal;

    always #5 clk = ~clk;

    decode_operand_stage_rv32i #(.W(32)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_rd(id_rd), .id_opcode(id_opcode), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .id_we(id_we), .id_is_load(id_is_load),
        .id_illegal(id_illegal)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7b5;
        logic        we;
        logic        ld;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t nxt;
    int   n_asrt = 0;
    int   n_fail = 0;

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] rs1v,
                                input logic [31:0] rs2v, input logic [31:0] imm,
                                input logic [4:0] rd, input logic [6:0] op, input logic [2:0] f3,
                                input logic f7b5, input logic we, input logic ld, input logic ill);
        exp_t e;
        e.pc = pc; e.rs1v = rs1v; e.rs2v = rs2v; e.imm = imm; e.rd = rd; e.op = op;
        e.f3 = f3; e.f7b5 = f7b5; e.we = we; e.ld = ld; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cmp_entry(input exp_t e);
        chk($sformatf("id_pc@%0h", e.pc),       id_pc,              e.pc);
        chk($sformatf("id_rs1_val@%0h", e.pc),  id_rs1_val,         e.rs1v);
        chk($sformatf("id_rs2_val@%0h", e.pc),  id_rs2_val,         e.rs2v);
        chk($sformatf("id_imm@%0h", e.pc),      id_imm,             e.imm);
        chk($sformatf("id_rd@%0h", e.pc),       32'(id_rd),         32'(e.rd));
        chk($sformatf("id_opcode@%0h", e.pc),   32'(id_opcode),     32'(e.op));
        chk($sformatf("id_funct3@%0h", e.pc),   32'(id_funct3),     32'(e.f3));
        chk($sformatf("id_funct7b5@%0h", e.pc), 32'(id_funct7b5),   32'(e.f7b5));
        chk($sformatf("id_we@%0h", e.pc),       32'(id_we),         32'(e.we));
        chk($sformatf("id_is_load@%0h", e.pc),  32'(id_is_load),    32'(e.ld));
        chk($sformatf("id_illegal@%0h", e.pc),  32'(id_illegal),    32'(e.ill));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"}, 32'(id_valid), 32'd0);
        chk({tag, "_pc"},    id_pc, 32'd0);
        chk({tag, "_ops"},   id_rs1_val | id_rs2_val, 32'd0);
        chk({tag, "_imm"},   id_imm, 32'd0);
        chk({tag, "_ctl"},   32'({id_rd, id_opcode, id_funct3, id_funct7b5, id_we, id_is_load, id_illegal}), 32'd0);
    endtask

    // Settle, account for the coming edge in the scoreboard, then advance one cycle.
    task automatic tick();
        #1;
        if (id_valid && id_ready) begin
            if (sb.size() == 0) begin
                n_asrt++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_underflow: observed pc 0x%08h expected no instruction", id_pc);
                end
            end else begin
                cmp_entry(sb.pop_front());
            end
        end else if (id_valid && flush && sb.size() != 0) begin
            void'(sb.pop_front());
        end
        if (if_valid && if_ready) sb.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    task automatic fwd_off();
        mem_fwd_we = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'd0;
        wb_fwd_we  = 1'b0; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'd0;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
        rf_rd1 = 32'd0; rf_rd2 = 32'd0; flush = 1'b0; id_ready = 1'b1;
        fwd_off();
        nxt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("reset");
        rst = 1'b0;
        #1;
        chk("if_ready_after_reset", 32'(if_ready), 32'd1);

        // addi x1,x0,5 : x0 source ignores a MEM write aimed at x0
        offer(32'h00500093, 32'h100);
        rf_rd1 = 32'h77; rf_rd2 = 32'h55;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hBAD;
        nxt = mk(32'h100, 32'h0, 32'h55, 32'd5, 5'd1, 7'h13, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("if_ready_addi1", 32'(if_ready), 32'd1);
        tick();
        chk("id_imm_addi1", id_imm, 32'd5);

        // addi x2,x1,3 with x1=5 only visible through WB
        fwd_off();
        offer(32'h00308113, 32'h104);
        rf_rd1 = 32'h99; rf_rd2 = 32'h66;
        wb_fwd_we = 1'b1; wb_fwd_rd = 5'd1; wb_fwd_data = 32'd5;
        nxt = mk(32'h104, 32'd5, 32'h66, 32'd3, 5'd2, 7'h13, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("if_ready_back_to_back", 32'(if_ready), 32'd1);
        tick();
        chk("id_valid_addi2", 32'(id_valid), 32'd1);
        chk("id_rs1_wb_fwd", id_rs1_val, 32'd5);

        // lw x3,0(x4)
        fwd_off();
        offer(32'h00022183, 32'h108);
        rf_rd1 = 32'h4000; rf_rd2 = 32'h0;
        nxt = mk(32'h108, 32'h4000, 32'h0, 32'h0, 5'd3, 7'h03, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();

        // add x5,x3,x6 : one-cycle load-use bubble, then MEM bypass
        offer(32'h006182B3, 32'h10C);
        rf_rd1 = 32'h1; rf_rd2 = 32'h600;
        nxt = mk(32'h10C, 32'hDEADBEEF, 32'h600, 32'h0, 5'd5, 7'h33, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("if_ready_load_use", 32'(if_ready), 32'd0);
        tick();
        chk("bubble_valid", 32'(id_valid), 32'd0);
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'hDEADBEEF;
        #1;
        chk("if_ready_after_bubble", 32'(if_ready), 32'd1);
        tick();
        chk("id_rs1_mem_fwd", id_rs1_val, 32'hDEADBEEF);

        // add x8,x0,x7 : MEM beats WB beats RF; x0 stays 0
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'h11;
        wb_fwd_we  = 1'b1; wb_fwd_rd  = 5'd7; wb_fwd_data  = 32'h22;
        rf_rd1 = 32'h44; rf_rd2 = 32'h33;
        offer(32'h00700433, 32'h110);
        nxt = mk(32'h110, 32'h0, 32'h11, 32'h0, 5'd8, 7'h33, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // sw x7,8(x0) : MEM idle so WB wins over RF
        mem_fwd_we = 1'b0;
        offer(32'h00702423, 32'h114);
        nxt = mk(32'h114, 32'h0, 32'h22, 32'd8, 5'd8, 7'h23, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // execute stalls three cycles while beq x1,x2,-4 waits
        fwd_off();
        id_ready = 1'b0;
        rf_rd1 = 32'h1111; rf_rd2 = 32'h2222;
        offer(32'hFE208EE3, 32'h118);
        nxt = mk(32'h118, 32'h1111, 32'h2222, 32'hFFFFFFFC, 5'd29, 7'h63, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_if_ready", i), 32'(if_ready), 32'd0);
            chk($sformatf("stall%0d_id_pc", i), id_pc, 32'h114);
            chk($sformatf("stall%0d_id_imm", i), id_imm, 32'd8);
            tick();
        end
        id_ready = 1'b1;
        #1;
        chk("if_ready_release", 32'(if_ready), 32'd1);
        tick();
        chk("id_pc_after_release", id_pc, 32'h118);

        // lui x1,0xABCDE
        rf_rd1 = 32'hA1; rf_rd2 = 32'hA2;
        offer(32'hABCDE0B7, 32'h11C);
        nxt = mk(32'h11C, 32'hA1, 32'hA2, 32'hABCDE000, 5'd1, 7'h37, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // ecall : unsupported opcode still flows through, flagged illegal
        rf_rd1 = 32'h0; rf_rd2 = 32'h0;
        offer(32'h00000073, 32'h120);
        nxt = mk(32'h120, 32'h0, 32'h0, 32'h0, 5'd0, 7'h73, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("id_illegal_ecall", 32'(id_illegal), 32'd1);
        if_valid = 1'b0;
        tick();
        chk("drained_valid", 32'(id_valid), 32'd0);

        // flush kills the held addi x9 and refuses the offered addi x10
        id_ready = 1'b0;
        offer(32'h00100493, 32'h124);
        nxt = mk(32'h124, 32'h0, 32'h0, 32'd1, 5'd9, 7'h13, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("held_before_flush", 32'(id_valid), 32'd1);
        flush = 1'b1;
        offer(32'h00200513, 32'h128);
        nxt = mk(32'h128, 32'h0, 32'h0, 32'd2, 5'd10, 7'h13, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("if_ready_flush", 32'(if_ready), 32'd0);
        tick();
        chk("flush_valid", 32'(id_valid), 32'd0);
        flush = 1'b0;
        id_ready = 1'b1;
        tick();
        if_valid = 1'b0;
        tick();

        // asynchronous reset with a held instruction
        id_ready = 1'b0;
        rf_rd1 = 32'h5; rf_rd2 = 32'h6;
        offer(32'hABCDE0B7, 32'h200);
        tick();
        chk("held_before_reset", 32'(id_valid), 32'd1);
        if_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_cleared("async_reset");
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        id_ready = 1'b1;
        #1;
        chk("if_ready_after_midreset", 32'(if_ready), 32'd1);
        tick();
        chk("idle_after_midreset", 32'(id_valid), 32'd0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
